// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Streams a program image into an 8-bit-wide instruction memory and holds the
// microprocessor in reset until a complete image with a valid checksum has
// been loaded.
//
// Stream format after each load_start pulse:
//   byte 0        : length N (0 encodes 2^AW)
//   bytes 1..N    : instructions, written to addresses 0..N-1
//   byte N+1      : checksum c, accepted when (sum of instructions + c) mod 256 == 0
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   synchronous reset, active low
//   load_start in   one-cycle pulse that (re)starts a load; wins over a transfer
//   in_valid   in   source presents a byte on in_data
//   in_data    in   program stream byte
//   in_ready   out  loader accepts a byte (HEADER, LOAD, CHECK only)
//   mem_we     out  instruction-memory write strobe (one cycle after transfer)
//   mem_addr   out  write address, holds when mem_we=0
//   mem_wdata  out  write data, holds when mem_we=0
//   cpu_hold   out  holds the CPU in reset; low only after a successful load
//   done       out  last load completed with a valid checksum
//   err        out  last load failed its checksum
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_LOAD,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_q,     state_d;
   logic [AW-1:0] index_q,     index_d;
   logic [AW-1:0] last_q,      last_d;
   logic [7:0]    sum_q,       sum_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          done_q,      done_d;
   logic          err_q,       err_d;

   logic          xfer;
   logic [7:0]    sum_plus;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         last_q      <= '0;
         sum_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         last_q      <= last_d;
         sum_q       <= sum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      last_d      = last_q;
      sum_d       = sum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      err_d       = err_q;

      in_ready = (state_q == S_HEADER) || (state_q == S_LOAD) || (state_q == S_CHECK);
      xfer     = in_valid && in_ready;
      sum_plus = sum_q + in_data;

      if (load_start) begin
         // A byte offered in the same cycle is dropped on purpose.
         state_d = S_HEADER;
         index_d = '0;
         sum_d   = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else if (xfer) begin
         unique case (state_q)
            S_HEADER: begin
               // Keep N-1 instead of N: a length byte of 0 wraps to the
               // all-ones address, so 2^AW bytes end exactly at the top word
               // and the index never needs to count past AW bits.
               last_d  = AW'(in_data) - AW'(1);
               state_d = S_LOAD;
            end
            S_LOAD: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = index_q;
               mem_wdata_d = in_data;
               sum_d       = sum_plus;
               if (index_q == last_q) begin
                  state_d = S_CHECK;
               end else begin
                  index_d = index_q + AW'(1);
               end
            end
            S_CHECK: begin
               if (sum_plus == 8'h00) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = (state_q != S_DONE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Scoreboarded bench for imem_loader. Stimulus builds whole program streams,
// derives the expected memory writes and load outcome from the stream format
// (length, data, checksum) and queues them; an independent monitor pops and
// compares whenever the loader strobes mem_we or raises done/err.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       done;
   logic       err;

   imem_loader #(.AW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] wq[$];     // expected {addr, data}
   logic [1:0]  rq[$];     // expected {done, err}
   logic [7:0]  stream[$]; // stream for the next run_load
   logic        mon_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples 1ns after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
               chk("spurious_write", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
            end else begin
               chk("write", 32'({mem_addr, mem_wdata}), 32'(wq.pop_front()));
            end
         end
         if ((done || err) && !mon_prev) begin
            chk("done_err_exclusive", 32'(done && err), 32'd0);
            if (rq.size() == 0) begin
               chk("unexpected_result", 32'({done, err}), 32'd0);
            end else begin
               logic [1:0] r;
               r = rq.pop_front();
               chk("result", 32'({done, err}), 32'(r));
               chk("result_cpu_hold", 32'(cpu_hold), 32'(!r[1]));
            end
         end
         mon_prev = done || err;
      end
   end

   // Offer one byte; gapmode 0: back-to-back, 1: one idle cycle first,
   // 2: random 0..3 idle cycles first. Starts and ends just after a negedge.
   task automatic send(input logic [7:0] b, input int gapmode);
      int  idle;
      logic acc;
      idle = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (idle) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 50; t++) begin
         acc = in_ready;
         @(negedge clk);
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      chk("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Pulse load_start, queue expectations from the stream, send the first
   // nsend bytes, then wait for the scoreboard to drain.
   task automatic run_load(input int gapmode, input int nsend, input bit junk);
      int n;
      int sum;
      load_start = 1'b1;
      in_valid   = junk;
      in_data    = 8'($urandom);
      @(negedge clk);
      load_start = 1'b0;
      in_valid   = 1'b0;
      chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("start_flags", 32'({done, err}), 32'd0);
      chk("start_ready", 32'(in_ready), 32'd1);

      n   = (stream[0] == 8'h00) ? 256 : int'(stream[0]);
      sum = 0;
      for (int k = 0; k < n; k++) begin
         sum += int'(stream[1 + k]);
         if (1 + k < nsend) wq.push_back({8'(k), stream[1 + k]});
      end
      if (nsend == n + 2)
         rq.push_back(((sum + int'(stream[n + 1])) % 256 == 0) ? 2'b10 : 2'b01);

      for (int i = 0; i < nsend; i++) send(stream[i], gapmode);

      for (int t = 0; t < 20 && (wq.size() != 0 || rq.size() != 0); t++) @(negedge clk);
      chk("drain", 32'(wq.size() + rq.size()), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s;
      int nsend;
      logic [7:0] b;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_flags", 32'({done, err}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd0);

      // Good three-byte image; checksum makes the byte sum zero mod 256.
      stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_load(0, 5, 0);
      chk("good_done", 32'(done), 32'd1);
      chk("good_err", 32'(err), 32'd0);
      chk("good_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("done_ready", 32'(in_ready), 32'd0);

      // Same image, bad checksum.
      stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
      run_load(0, 5, 0);
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_done", 32'(done), 32'd0);
      chk("bad_cpu_hold", 32'(cpu_hold), 32'd1);
      repeat (2) @(negedge clk);
      chk("bad_err_holds", 32'(err), 32'd1);

      // Full-depth image: length 0 means 256 bytes.
      stream.delete();
      stream.push_back(8'h00);
      repeat (256) stream.push_back(8'h01);
      stream.push_back(8'h00);
      run_load(0, 258, 0);
      chk("full_done", 32'(done), 32'd1);

      // in_valid toggling every other cycle.
      stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_load(1, 5, 0);
      chk("gap_done", 32'(done), 32'd1);
      chk("gap_cpu_hold", 32'(cpu_hold), 32'd0);

      // Abort after two data bytes, restart with a byte offered during load_start.
      stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_load(0, 3, 0);
      stream = '{8'h02, 8'hAA, 8'hBB, 8'h9B};
      run_load(0, 4, 1);
      chk("abort_done", 32'(done), 32'd1);

      // Randomized images, some aborted part-way.
      for (int r = 0; r < 12; r++) begin
         n = int'($urandom_range(1, 24));
         stream.delete();
         stream.push_back(8'(n));
         s = 0;
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            s += int'(b);
            stream.push_back(b);
         end
         stream.push_back(($urandom_range(0, 1) == 1) ? 8'(256 - s % 256) : 8'($urandom));
         nsend = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n + 1)) : n + 2;
         run_load(2, nsend, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a load.
      stream = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1};
      run_load(0, 3, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      chk("midrst_we", 32'(mem_we), 32'd0);
      chk("midrst_addr", 32'(mem_addr), 32'd0);
      chk("midrst_wdata", 32'(mem_wdata), 32'd0);
      chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("midrst_flags", 32'({done, err}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Recovery after reset.
      stream = '{8'h02, 8'hAA, 8'hBB, 8'h9B};
      run_load(2, 4, 0);
      chk("recover_done", 32'(done), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
